// File: rtl/aligner_ctrl.sv
// aligner_ctrl: sequences beats into the byte aligner and buffers aligned words in a 2-entry FIFO (ALIGNER_CTRL_STATS_EN adds counters)
module aligner_ctrl #(
  parameter int DATA_IN_WIDTH  = 272,
  parameter int LEN_WIDTH      = 8,
  parameter int DATA_OUT_WIDTH = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_IN_WIDTH-1:0]    s_data,
  input  logic [LEN_WIDTH-1:0]        s_len,
  input  logic                        s_comp,
  input  logic                        s_last,
  output logic                        al_wrt_en,
  output logic [DATA_IN_WIDTH-1:0]    al_data,
  output logic [LEN_WIDTH-1:0]        al_len,
  output logic [3:0]                  al_flags,
  input  logic [2:0]                  al_flags_out,
  input  logic [DATA_OUT_WIDTH-1:0]   al_data_out,
  input  logic [DATA_OUT_WIDTH/8-1:0] al_tkeep,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_OUT_WIDTH-1:0]   m_data,
  output logic [DATA_OUT_WIDTH/8-1:0] m_keep,
  output logic                        m_last
`ifdef ALIGNER_CTRL_STATS_EN
  ,
  output logic [31:0]                 stat_pkts,
  output logic [31:0]                 stat_words,
  output logic [15:0]                 stat_stalls
`endif
);
  localparam int KW = DATA_OUT_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FLUSH} state_t;
  state_t state, state_nxt;
  logic run, last_pend, last_pend_nxt, accept, pop, push, room, rptr, wptr;
  logic [1:0] count;
  logic [DATA_OUT_WIDTH-1:0] mem_data [2];
  logic [KW-1:0] mem_keep [2];
  logic [1:0] mem_last;
  assign m_valid = count != 2'd0;
  assign m_data  = mem_data[rptr];
  assign m_keep  = mem_keep[rptr];
  assign m_last  = mem_last[rptr];
  assign pop     = m_valid & m_ready;
  // a pop in the same cycle frees a slot, so a full FIFO can still take a word
  assign room    = run & (!count[1] | pop);
  assign push    = al_wrt_en & al_flags_out[2];
  always_comb begin
    state_nxt     = state;
    last_pend_nxt = last_pend;
    s_ready       = 1'b0;
    accept        = 1'b0;
    al_wrt_en     = 1'b0;
    al_data       = '0;
    al_len        = '0;
    al_flags      = 4'b0000;
    case (state)
      IDLE, STREAM: begin
        s_ready = room;
        accept  = s_valid & room;
        if (accept) begin
          al_wrt_en = 1'b1;
          al_data   = s_data;
          al_len    = s_len;
          al_flags  = {1'b1, s_last, s_comp, state == IDLE};
          if (state == STREAM && al_flags_out[1]) begin
            state_nxt     = DRAIN;
            last_pend_nxt = s_last;
          end else if (s_last) state_nxt = al_flags_out[0] ? IDLE : FLUSH;
          else state_nxt = STREAM;
        end
      end
      default: if (room) begin
        al_wrt_en = 1'b1;
        al_flags  = 4'b1010;
        state_nxt = state == FLUSH ? IDLE : last_pend ? FLUSH : STREAM;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_pend <= 1'b0;
      run       <= 1'b0;
      count     <= 2'd0;
      rptr      <= 1'b0;
      wptr      <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_pend <= last_pend_nxt;
      run       <= 1'b1;
      count     <= count + {1'b0, push} - {1'b0, pop};
      rptr      <= rptr ^ pop;
      wptr      <= wptr ^ push;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr] <= al_data_out;
      mem_keep[wptr] <= al_tkeep;
      mem_last[wptr] <= al_flags_out[0];
    end
  end
`ifdef ALIGNER_CTRL_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_pkts   <= '0;
      stat_words  <= '0;
      stat_stalls <= '0;
    end else begin
      stat_pkts   <= stat_pkts + 32'(pop & m_last);
      stat_words  <= stat_words + 32'(pop);
      stat_stalls <= stat_stalls + 16'(accept & (state == STREAM) & al_flags_out[1]);
    end
  end
`endif
endmodule

// File: tb/tb_aligner_ctrl.sv
// tb_aligner_ctrl: directed stimulus with the bench acting as the byte aligner
module tb_aligner_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  logic s_valid, s_ready, s_comp, s_last, al_wrt_en, m_valid, m_ready, m_last;
  logic [271:0] s_data, al_data;
  logic [7:0] s_len, al_len;
  logic [3:0] al_flags;
  logic [2:0] al_flags_out;
  logic [255:0] al_data_out, m_data;
  logic [31:0] al_tkeep, m_keep;
  int checks = 0, failures = 0;
  aligner_ctrl dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_len(s_len), .s_comp(s_comp), .s_last(s_last), .al_wrt_en(al_wrt_en), .al_data(al_data),
    .al_len(al_len), .al_flags(al_flags), .al_flags_out(al_flags_out), .al_data_out(al_data_out),
    .al_tkeep(al_tkeep), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
    .m_last(m_last)
  );
  function automatic logic [255:0] w(input logic [31:0] n);
    return {8{n}};
  endfunction
  task automatic chk(input string tag, input logic [271:0] obs, input logic [271:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [31:0] n, input logic [7:0] len, input logic comp,
                     input logic last, input logic [2:0] fo, input logic [31:0] on, input logic [31:0] keep);
    s_valid = v; s_data = {16'h0, w(n)}; s_len = len; s_comp = comp; s_last = last;
    al_flags_out = fo; al_data_out = w(on); al_tkeep = keep;
    #1;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic [31:0] n, input logic [31:0] keep, input logic last);
    chk({tag, ".m_valid"}, m_valid, 1'b1);
    chk({tag, ".m_data"}, m_data, w(n));
    chk({tag, ".m_keep"}, m_keep, keep);
    chk({tag, ".m_last"}, m_last, last);
  endtask
  initial begin
    m_ready = 1'b1;
    drv(1, 32'h1, 8'd32, 1, 0, 3'b100, 32'h1, '1);
    #10;
    chk("rst.m_valid", m_valid, 1'b0);
    chk("rst.s_ready", s_ready, 1'b0);
    chk("rst.al_wrt_en", al_wrt_en, 1'b0);
    chk("rst.al_flags", al_flags, 4'b0000);
    reset = 1'b1;
    step;
    // 1: header + 4 full beats, one word per beat
    drv(1, 32'h10, 8'd32, 1, 0, 3'b100, 32'h1A, '1);
    chk("t1.s_ready", s_ready, 1'b1);
    chk("t1.al_wrt_en", al_wrt_en, 1'b1);
    chk("t1.hdr_flags", al_flags, 4'b1011);
    chk("t1.al_data", al_data, {16'h0, w(32'h10)});
    step;
    chk_out("t1.w0", 32'h1A, '1, 0);
    for (int i = 1; i <= 4; i++) begin
      drv(1, 32'h10 + i, 8'd32, 1, i == 4, i == 4 ? 3'b101 : 3'b100, 32'h1A + i, '1);
      chk("t1.flags", al_flags, {1'b1, i == 4, 1'b1, 1'b0});
      chk("t1.al_len", al_len, 8'd32);
      step;
      chk_out("t1.w", 32'h1A + i, '1, i == 4);
    end
    drv(0, 0, 0, 0, 0, 3'b000, 0, 0);
    chk("t1.idle_flags", al_flags, 4'b0000);
    chk("t1.idle_wrt", al_wrt_en, 1'b0);
    chk("t1.idle_ready", s_ready, 1'b1);
    step;
    chk("t1.drained", m_valid, 1'b0);
    // 2: header + 20,20,10 bytes -> two words, last one partial
    drv(1, 32'h20, 8'd32, 1, 0, 3'b000, 0, 0);
    step;
    chk("t2.nopush0", m_valid, 1'b0);
    drv(1, 32'h21, 8'd20, 1, 0, 3'b000, 0, 0);
    step;
    chk("t2.nopush1", m_valid, 1'b0);
    drv(1, 32'h22, 8'd20, 1, 0, 3'b100, 32'h2A, '1);
    step;
    chk_out("t2.w0", 32'h2A, '1, 0);
    drv(1, 32'h23, 8'd10, 1, 1, 3'b101, 32'h2B, 32'h0003FFFF);
    chk("t2.al_len", al_len, 8'd10);
    chk("t2.flags", al_flags, 4'b1110);
    step;
    chk_out("t2.w1", 32'h2B, 32'h0003FFFF, 1);
    drv(0, 0, 0, 0, 0, 3'b000, 0, 0);
    step;
    chk("t2.drained", m_valid, 1'b0);
    // 3: stall -> one DRAIN write, no beat lost
    drv(1, 32'h30, 8'd32, 1, 0, 3'b000, 0, 0);
    step;
    drv(1, 32'h31, 8'd32, 1, 0, 3'b010, 0, 0);
    chk("t3.stall_wrt", al_wrt_en, 1'b1);
    step;
    drv(1, 32'h32, 8'd32, 1, 1, 3'b100, 32'h3A, '1);
    chk("t3.drain_ready", s_ready, 1'b0);
    chk("t3.drain_wrt", al_wrt_en, 1'b1);
    chk("t3.drain_len", al_len, 8'd0);
    chk("t3.drain_data", al_data, 272'h0);
    chk("t3.drain_flags", al_flags, 4'b1010);
    step;
    chk_out("t3.w0", 32'h3A, '1, 0);
    drv(1, 32'h32, 8'd32, 1, 1, 3'b101, 32'h3B, '1);
    chk("t3.resume_ready", s_ready, 1'b1);
    chk("t3.resume_data", al_data, {16'h0, w(32'h32)});
    step;
    chk_out("t3.w1", 32'h3B, '1, 1);
    drv(0, 0, 0, 0, 0, 3'b000, 0, 0);
    step;
    chk("t3.drained", m_valid, 1'b0);
    // 4: overflowing last beat -> FLUSH then IDLE
    drv(1, 32'h40, 8'd32, 1, 0, 3'b000, 0, 0);
    step;
    drv(1, 32'h41, 8'd30, 1, 1, 3'b100, 32'h4A, '1);
    step;
    chk_out("t4.w0", 32'h4A, '1, 0);
    drv(0, 0, 0, 0, 0, 3'b101, 32'h4B, 32'h000000FF);
    chk("t4.flush_ready", s_ready, 1'b0);
    chk("t4.flush_wrt", al_wrt_en, 1'b1);
    chk("t4.flush_flags", al_flags, 4'b1010);
    chk("t4.flush_len", al_len, 8'd0);
    step;
    chk_out("t4.w1", 32'h4B, 32'h000000FF, 1);
    drv(0, 0, 0, 0, 0, 3'b000, 0, 0);
    chk("t4.idle_ready", s_ready, 1'b1);
    chk("t4.idle_wrt", al_wrt_en, 1'b0);
    step;
    chk("t4.drained", m_valid, 1'b0);
    // 5: backpressure fills the FIFO, then resumes in order
    m_ready = 1'b0;
    drv(1, 32'h50, 8'd32, 1, 0, 3'b100, 32'h5A, '1);
    step;
    chk_out("t5.w0", 32'h5A, '1, 0);
    drv(1, 32'h51, 8'd32, 1, 0, 3'b100, 32'h5B, '1);
    step;
    chk_out("t5.hold0", 32'h5A, '1, 0);
    drv(1, 32'h52, 8'd32, 1, 0, 3'b100, 32'h5C, '1);
    for (int i = 0; i < 10; i++) begin
      chk("t5.full_ready", s_ready, 1'b0);
      chk("t5.full_wrt", al_wrt_en, 1'b0);
      chk("t5.stable", m_data, w(32'h5A));
      step;
    end
    m_ready = 1'b1;
    drv(1, 32'h52, 8'd32, 1, 0, 3'b100, 32'h5C, '1);
    chk("t5.popfree_ready", s_ready, 1'b1);
    chk("t5.popfree_wrt", al_wrt_en, 1'b1);
    step;
    chk_out("t5.w1", 32'h5B, '1, 0);
    drv(1, 32'h53, 8'd32, 1, 1, 3'b101, 32'h5D, '1);
    step;
    chk_out("t5.w2", 32'h5C, '1, 0);
    drv(0, 0, 0, 0, 0, 3'b000, 0, 0);
    step;
    chk_out("t5.w3", 32'h5D, '1, 1);
    step;
    chk("t5.drained", m_valid, 1'b0);
    // 6: reset mid-packet with a full FIFO
    m_ready = 1'b0;
    drv(1, 32'h60, 8'd32, 1, 0, 3'b100, 32'h6A, '1);
    step;
    drv(1, 32'h61, 8'd32, 1, 0, 3'b100, 32'h6B, '1);
    step;
    chk_out("t6.full", 32'h6A, '1, 0);
    reset = 1'b0;
    #1;
    chk("t6.rst_m_valid", m_valid, 1'b0);
    chk("t6.rst_s_ready", s_ready, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    m_ready = 1'b1;
    step;
    drv(1, 32'h70, 8'd32, 1, 0, 3'b000, 0, 0);
    chk("t6.new_hdr", al_flags, 4'b1011);
    chk("t6.new_ready", s_ready, 1'b1);
    step;
    drv(0, 0, 0, 0, 0, 3'b000, 0, 0);
    chk("t6.empty", m_valid, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
